lane_sum_pipe: RTL and testbench

- Parametrised successor of the two-stage split-and-add pipeline.
- Splits an input word into LANES unsigned lanes of W bits each and reduces them through a registered binary adder tree.
- Adds valid/ready flow control, a selectable wrap/saturate mode and an overflow flag.
- Sits between an upstream producer and a downstream consumer as a fixed-latency streaming stage.

---
 rtl/lane_sum_pipe.sv | 89 ++++++++
 tb/tb_lane_sum_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_sum_pipe.sv
// Streaming lane reducer: splits a packed word into LANES unsigned W-bit lanes and sums
// them through a registered binary adder tree with valid/ready flow control.
module lane_sum_pipe #(
    parameter int W        = 32,
    parameter int LANES    = 2,
    parameter int SATURATE = 0,
    localparam int LEVELS  = $clog2(LANES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic               out_overflow
);

    // Stage 0 holds the raw lanes; stage k holds LANES>>k partial sums.
    // Entries beyond a level's width stay zero and are never read.
    logic [LEVELS:0] valid;
    logic [W-1:0]    data [LEVELS+1][LANES];
    logic            ovf  [LEVELS+1][LANES];
    logic            advance;

    function automatic logic [W-1:0] node_sum(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (SATURATE != 0 && s[W]) begin
            return '1;
        end
        return s[W-1:0];
    endfunction

    function automatic logic node_carry(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W];
    endfunction

    // The whole pipe freezes only when the output word is offered but not taken.
    assign advance  = ~(out_valid & ~out_ready);
    assign in_ready = advance;

    always_ff @(posedge clk) begin
        // NOTE: every register here is state, so only non-blocking assignments; blocking
        // ones would let a later stage see this cycle's update of an earlier one.
        if (!rst_n) begin
            // NOTE: data registers are reset as well as valid bits so the outputs read
            // zero straight after reset instead of stale in-flight values.
            valid <= '0;
            for (int k = 0; k <= LEVELS; k++) begin
                for (int j = 0; j < LANES; j++) begin
                    data[k][j] <= '0;
                    ovf[k][j]  <= 1'b0;
                end
            end
        end else if (advance) begin
            valid[0] <= in_valid;
            for (int j = 0; j < LANES; j++) begin
                data[0][j] <= in_valid ? in_data[j*W +: W] : '0;
                ovf[0][j]  <= 1'b0;
            end
            for (int k = 1; k <= LEVELS; k++) begin
                valid[k] <= valid[k-1];
                for (int j = 0; j < LANES / 2; j++) begin
                    if (valid[k-1] && j < (LANES >> k)) begin
                        data[k][j] <= node_sum(data[k-1][2*j], data[k-1][2*j+1]);
                        ovf[k][j]  <= node_carry(data[k-1][2*j], data[k-1][2*j+1])
                                      | ovf[k-1][2*j] | ovf[k-1][2*j+1];
                    end else begin
                        data[k][j] <= '0;
                        ovf[k][j]  <= 1'b0;
                    end
                end
                for (int j = LANES / 2; j < LANES; j++) begin
                    data[k][j] <= '0;
                    ovf[k][j]  <= 1'b0;
                end
            end
        end
    end

    assign out_valid    = valid[LEVELS];
    assign out_data     = data[LEVELS][0];
    assign out_overflow = ovf[LEVELS][0];

endmodule

// File: tb/tb_lane_sum_pipe.sv
// Scoreboard bench for lane_sum_pipe: a 32x2 wrap, a 32x2 saturating and an 8x8 wrap
// instance see the same 64-bit words; a negedge monitor checks every output handshake.
module tb_lane_sum_pipe;

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        int          cyc;
        bit          chk_lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ovf;
    logic        out_ready;
    logic [31:0] out_a, out_s;
    logic [7:0]  out_b;
    logic [31:0] od [3];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    bit   rand_mode = 0;
    bit   steady = 1;
    logic ready_cmd = 1'b1;
    exp_t sb0 [$];
    exp_t sb1 [$];
    exp_t sb2 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lane_sum_pipe #(.W(32), .LANES(2), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_data(out_a), .out_overflow(out_ovf[0]));

    lane_sum_pipe #(.W(32), .LANES(2), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_data(out_s), .out_overflow(out_ovf[1]));

    lane_sum_pipe #(.W(8), .LANES(8), .SATURATE(0)) u_oct (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data), .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_data(out_b), .out_overflow(out_ovf[2]));

    always_comb begin
        od[0] = out_a;
        od[1] = out_s;
        od[2] = {24'h0, out_b};
    end

    function automatic int lat(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    task automatic push(input int i, input logic [31:0] d, input logic o);
        exp_t e;
        e.data = d; e.ovf = o; e.cyc = cyc; e.chk_lat = steady;
        case (i)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic pop(input int i, output exp_t e);
        case (i)
            0:       e = sb0.pop_front();
            1:       e = sb1.pop_front();
            default: e = sb2.pop_front();
        endcase
    endtask

    // Offer one word to all three instances; each accepts on its own handshake.
    task automatic send(input logic [63:0] d,
                        input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                        input logic o0, input logic o1, input logic o2, input bit track);
        bit acc [3];
        int budget = 0;
        in_data  = d;
        in_valid = 3'b111;
        while (in_valid != 3'b000 && budget < 200) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) acc[i] = in_valid[i] && in_ready[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) begin
                    in_valid[i] = 1'b0;
                    if (track) push(i, (i == 0) ? e0 : (i == 1) ? e1 : e2,
                                    (i == 0) ? o0 : (i == 1) ? o1 : o2);
                end
            end
            budget++;
        end
        if (in_valid != 3'b000) begin
            n_checks++; n_errors++;
            $display("FAIL send timeout: in_valid still %b", in_valid);
            in_valid = 3'b000;
        end
    endtask

    task automatic send_model(input logic [63:0] d);
        logic [32:0] s;
        int bs = 0;
        s = {1'b0, d[31:0]} + {1'b0, d[63:32]};
        for (int i = 0; i < 8; i++) bs += int'(d[i*8 +: 8]);
        send(d, s[31:0], s[32] ? 32'hFFFF_FFFF : s[31:0], 32'(bs % 256),
             s[32], s[32], bs >= 256, 1'b1);
    endtask

    task automatic wait_drain();
        int budget = 0;
        while ((qsize(0) + qsize(1) + qsize(2)) != 0 && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        #1;
        check("drain", 32'(qsize(0) + qsize(1) + qsize(2)), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s dut%0d out_valid", tag, i), 32'(out_valid[i]), 32'd0);
            check($sformatf("%s dut%0d out_data", tag, i), od[i], 32'd0);
            check($sformatf("%s dut%0d out_overflow", tag, i), 32'(out_ovf[i]), 32'd0);
            check($sformatf("%s dut%0d in_ready", tag, i), 32'(in_ready[i]), 32'd1);
        end
    endtask

    // Sole driver of out_ready, updated just after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_cmd;
        end
    end

    // Monitor: handshake invariant, stall hold, and in-order scoreboard compare.
    initial begin
        bit          prev_stall [3];
        logic [31:0] prev_d [3];
        logic        prev_o [3];
        exp_t        e;
        for (int i = 0; i < 3; i++) prev_stall[i] = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                for (int i = 0; i < 3; i++) prev_stall[i] = 0;
            end else if (mon_en) begin
                for (int i = 0; i < 3; i++) begin
                    check($sformatf("dut%0d in_ready", i), 32'(in_ready[i]),
                          32'(!(out_valid[i] && !out_ready)));
                    if (prev_stall[i]) begin
                        check($sformatf("dut%0d hold data", i), od[i], prev_d[i]);
                        check($sformatf("dut%0d hold ovf", i), 32'(out_ovf[i]), 32'(prev_o[i]));
                    end
                    if (out_valid[i] && out_ready) begin
                        if (qsize(i) == 0) begin
                            n_checks++; n_errors++;
                            $display("FAIL dut%0d unexpected output: got %h want none", i, od[i]);
                        end else begin
                            pop(i, e);
                            check($sformatf("dut%0d data", i), od[i], e.data);
                            check($sformatf("dut%0d overflow", i), 32'(out_ovf[i]), 32'(e.ovf));
                            if (e.chk_lat)
                                check($sformatf("dut%0d latency", i), 32'(cyc), 32'(e.cyc + lat(i)));
                        end
                    end
                    prev_stall[i] = out_valid[i] && !out_ready;
                    prev_d[i]     = od[i];
                    prev_o[i]     = out_ovf[i];
                end
            end
        end
    end

    typedef struct {
        logic [63:0] d;
        logic [31:0] e0, e1, e2;
        logic        o0, o1, o2;
    } vec_t;

    vec_t vecs [10] = '{
        '{64'h00000005_00000003, 32'h8,         32'h8,         32'h08, 1'b0, 1'b0, 1'b0},
        '{64'hFFFFFFFF_00000002, 32'h1,         32'hFFFFFFFF,  32'hFE, 1'b1, 1'b1, 1'b1},
        '{64'h08070605_04030201, 32'h0C0A0806,  32'h0C0A0806,  32'h24, 1'b0, 1'b0, 1'b0},
        '{64'h40404040_40404040, 32'h80808080,  32'h80808080,  32'h00, 1'b0, 1'b0, 1'b1},
        '{64'h00000000_0000FF00, 32'h0000FF00,  32'h0000FF00,  32'hFF, 1'b0, 1'b0, 1'b0},
        '{64'h00000000_000001FF, 32'h000001FF,  32'h000001FF,  32'h00, 1'b0, 1'b0, 1'b1},
        '{64'hFFFFFFFF_00000000, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFC, 1'b0, 1'b0, 1'b1},
        '{64'hFFFFFFFF_00000001, 32'h00000000,  32'hFFFFFFFF,  32'hFD, 1'b1, 1'b1, 1'b1},
        '{64'h00000000_00000000, 32'h00000000,  32'h00000000,  32'h00, 1'b0, 1'b0, 1'b0},
        '{64'hFFFFFFFF_FFFFFFFF, 32'hFFFFFFFE,  32'hFFFFFFFF,  32'hF8, 1'b1, 1'b1, 1'b1}
    };

    initial begin
        rst_n    = 1'b0;
        in_valid = 3'b000;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n  = 1'b1;
        mon_en = 1;

        // Single word followed by bubbles, then the rest back-to-back.
        send(vecs[0].d, vecs[0].e0, vecs[0].e1, vecs[0].e2,
             vecs[0].o0, vecs[0].o1, vecs[0].o2, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        for (int v = 1; v < 10; v++)
            send(vecs[v].d, vecs[v].e0, vecs[v].e1, vecs[v].e2,
                 vecs[v].o0, vecs[v].o1, vecs[v].o2, 1'b1);
        wait_drain();

        for (int n = 0; n < 16; n++) send_model({$urandom, $urandom});
        wait_drain();

        // Random backpressure: latency is no longer fixed, order and content still are.
        steady    = 0;
        rand_mode = 1;
        for (int n = 0; n < 16; n++) send_model({$urandom, $urandom});
        rand_mode = 0;
        ready_cmd = 1'b1;
        wait_drain();

        // Fill with the consumer blocked, hold five cycles, then release.
        ready_cmd = 1'b0;
        send_model(64'h00000010_00000020);
        send_model(64'hFFFFFFF0_00000030);
        repeat (5) @(posedge clk);
        #1;
        check("stall dut0 out_valid", 32'(out_valid[0]), 32'd1);
        check("stall dut0 in_ready", 32'(in_ready[0]), 32'd0);
        check("stall dut0 data", od[0], 32'h00000030);
        ready_cmd = 1'b1;
        wait_drain();

        // Two words in flight, then a one-cycle reset: neither may ever appear.
        ready_cmd = 1'b0;
        send(64'h11111111_22222222, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(64'h33333333_44444444, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_idle("post-reset");
        ready_cmd = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post-reset queues", 32'(qsize(0) + qsize(1) + qsize(2)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got cycle %0d want finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
